// File: rtl/fc_prop_monitor_if.sv
// Bus bundle for fc_prop_monitor: per-channel check controls in, sticky
// error status, first-error capture and violation counters out.
interface fc_prop_monitor_if #(
    parameter int NUM_CHK = 4,
    parameter int LAT_W   = 5,
    parameter int CNT_W   = 8,
    parameter int ID_W    = 2
);
    logic [NUM_CHK-1:0]            chk_en_i;
    logic [NUM_CHK-1:0]            trig_i;
    logic [NUM_CHK-1:0]            cond_i;
    logic [NUM_CHK-1:0]            mode_i;
    logic [NUM_CHK-1:0][LAT_W-1:0] lat_i;
    logic                          clr_i;
    logic [NUM_CHK-1:0]            err_o;
    logic                          first_err_vld_o;
    logic [ID_W-1:0]               first_err_id_o;
    logic                          irq_o;
    logic [NUM_CHK-1:0][CNT_W-1:0] viol_cnt_o;

    modport master (
        output chk_en_i, trig_i, cond_i, mode_i, lat_i, clr_i,
        input  err_o, first_err_vld_o, first_err_id_o, irq_o, viol_cnt_o
    );

    modport slave (
        input  chk_en_i, trig_i, cond_i, mode_i, lat_i, clr_i,
        output err_o, first_err_vld_o, first_err_id_o, irq_o, viol_cnt_o
    );
endinterface

// File: rtl/fc_prop_monitor.sv
// Runtime implication checker: NUM_CHK channels of "trig -> cond within/at N cycles".
// Define FC_PROP_MON_VIOL_CNT_EN to build the per-channel saturating violation counters.
module fc_prop_chan #(
    parameter int LAT_W   = 5,
    parameter int MAX_LAT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             trig,
    input  logic             cond,
    input  logic             mode,
    input  logic [LAT_W-1:0] lat,
    output logic             viol
);
    typedef enum logic {IDLE, ARMED} state_t;

    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

    state_t           state_q, state_n;
    logic [LAT_W-1:0] cnt_q, cnt_n;
    logic [LAT_W-1:0] lat_c;
    logic             mode_q, mode_n;

    assign lat_c = (lat > LAT_MAX) ? LAT_MAX : lat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            mode_q  <= mode_n;
        end
    end

    // viol is combinational; the top registers it, and a disabled channel never reports
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        mode_n  = mode_q;
        viol    = 1'b0;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        if (lat_c == '0) begin
                            viol = !cond;
                        end else begin
                            cnt_n   = lat_c;
                            mode_n  = mode;
                            state_n = ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (!mode_q && cond) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt_q == LAT_W'(1)) begin
                        viol    = !cond;
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q - LAT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end
endmodule

module fc_prop_monitor #(
    parameter int NUM_CHK = 4,
    parameter int MAX_LAT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fc_prop_monitor_if.slave  bus
);
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int ID_W  = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;

    logic [NUM_CHK-1:0] viol;
    logic [NUM_CHK-1:0] err_q, err_n;
    logic               irq_q;
    logic               first_vld_q;
    logic [ID_W-1:0]    first_id_q, first_id_n;

    for (genvar g = 0; g < NUM_CHK; g++) begin : g_chan
        fc_prop_chan #(
            .LAT_W   (LAT_W),
            .MAX_LAT (MAX_LAT)
        ) u_chan (
            .clk  (clk_i),
            .rst  (rst_i),
            .en   (bus.chk_en_i[g]),
            .trig (bus.trig_i[g]),
            .cond (bus.cond_i[g]),
            .mode (bus.mode_i[g]),
            .lat  (bus.lat_i[g]),
            .viol (viol[g])
        );
    end

    // A violation coincident with clr survives the clear
    assign err_n = (bus.clr_i ? '0 : err_q) | viol;

    always_comb begin
        first_id_n = '0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (viol[i]) first_id_n = ID_W'(i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q       <= '0;
            irq_q       <= 1'b0;
            first_vld_q <= 1'b0;
            first_id_q  <= '0;
        end else begin
            err_q <= err_n;
            irq_q <= |err_n;
            if ((|viol) && (bus.clr_i || !first_vld_q)) begin
                first_vld_q <= 1'b1;
                first_id_q  <= first_id_n;
            end else if (bus.clr_i) begin
                first_vld_q <= 1'b0;
                first_id_q  <= '0;
            end
        end
    end

    assign bus.err_o           = err_q;
    assign bus.irq_o           = irq_q;
    assign bus.first_err_vld_o = first_vld_q;
    assign bus.first_err_id_o  = first_id_q;

`ifdef FC_PROP_MON_VIOL_CNT_EN
    logic [NUM_CHK-1:0][CNT_W-1:0] cnt_q;

    // Counters survive clr; only reset zeroes them
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CHK; i++) begin
                if (viol[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign bus.viol_cnt_o = cnt_q;
`else
    assign bus.viol_cnt_o = {NUM_CHK{{CNT_W{1'b0}}}};
`endif
endmodule

// File: tb/tb_fc_prop_monitor.sv
// Directed bench for fc_prop_monitor: AT/WITHIN timing, lat=0, clamp, priority,
// clear races, saturation, enable drop and mid-check reset.
module tb_fc_prop_monitor;
    localparam int NUM_CHK = 4;
    localparam int MAX_LAT = 16;
    localparam int LAT_W   = 5;
    localparam int CNT_W   = 8;
    localparam int ID_W    = 2;
`ifdef FC_PROP_MON_VIOL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [NUM_CHK-1:0][CNT_W-1:0] exp_cnt;

    always #5 clk = ~clk;

    fc_prop_monitor_if #(.NUM_CHK(NUM_CHK), .LAT_W(LAT_W), .CNT_W(CNT_W), .ID_W(ID_W)) bus ();

    fc_prop_monitor #(.NUM_CHK(NUM_CHK), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.chk_en_i = '1;
        bus.trig_i   = '0;
        bus.cond_i   = '0;
        bus.mode_i   = '0;
        bus.lat_i    = '0;
        bus.clr_i    = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL reset_err got %b want 0000", bus.err_o); end
        checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", bus.irq_o); end
        checks++; if (bus.first_err_vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", bus.first_err_vld_o); end
        checks++; if (bus.first_err_id_o !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", bus.first_err_id_o); end
        checks++; if (bus.viol_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt got %h want 0", bus.viol_cnt_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_at_mode();
        bus.mode_i[0] = 1'b1;
        bus.lat_i[0]  = 5'd10;
        bus.trig_i[0] = 1'b1; tick(); bus.trig_i[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin bus.cond_i[0] = (k == 10); tick(); end
        bus.cond_i[0] = 1'b0;
        checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL at_pass_err got %b want 0000", bus.err_o); end
        tick();
        bus.trig_i[0] = 1'b1; tick(); bus.trig_i[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            bus.cond_i[0] = (k == 9);
            tick();
            if (k == 9) begin
                checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL at_early_err got %b want 0000", bus.err_o); end
            end
        end
        bus.cond_i[0] = 1'b0;
        exp_cnt = '0;
        exp_cnt[0] = CNT_EN ? 8'd1 : 8'd0;
        checks++; if (bus.err_o !== 4'b0001) begin errors++; $display("FAIL at_viol_err got %b want 0001", bus.err_o); end
        checks++; if (bus.irq_o !== 1'b1) begin errors++; $display("FAIL at_viol_irq got %b want 1", bus.irq_o); end
        checks++; if (bus.first_err_vld_o !== 1'b1 || bus.first_err_id_o !== 2'd0) begin errors++; $display("FAIL at_first got vld %b id %0d want vld 1 id 0", bus.first_err_vld_o, bus.first_err_id_o); end
        checks++; if (bus.viol_cnt_o !== exp_cnt) begin errors++; $display("FAIL at_cnt got %h want %h", bus.viol_cnt_o, exp_cnt); end
        pulse_clr();
        checks++; if (bus.err_o !== 4'b0000 || bus.irq_o !== 1'b0 || bus.first_err_vld_o !== 1'b0) begin errors++; $display("FAIL at_clr got err %b irq %b vld %b want 0000 0 0", bus.err_o, bus.irq_o, bus.first_err_vld_o); end
    endtask

    task automatic test_within();
        bus.mode_i[1] = 1'b0;
        bus.lat_i[1]  = 5'd4;
        bus.trig_i[1] = 1'b1; tick(); bus.trig_i[1] = 1'b0;
        for (int k = 1; k <= 4; k++) begin bus.cond_i[1] = (k == 3); tick(); end
        bus.cond_i[1] = 1'b0;
        checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL within_pass_err got %b want 0000", bus.err_o); end
        tick();
        bus.trig_i[1] = 1'b1; tick();
        for (int k = 1; k <= 4; k++) begin
            bus.trig_i[1] = (k == 2);
            tick();
            if (k == 3) begin
                checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL within_early_err got %b want 0000", bus.err_o); end
            end
        end
        bus.trig_i[1] = 1'b0;
        checks++; if (bus.err_o !== 4'b0010 || bus.first_err_id_o !== 2'd1) begin errors++; $display("FAIL within_viol got err %b id %0d want 0010 id 1", bus.err_o, bus.first_err_id_o); end
        repeat (6) tick();
        exp_cnt[1] = CNT_EN ? 8'd1 : 8'd0;
        checks++; if (bus.viol_cnt_o !== exp_cnt || bus.err_o !== 4'b0010) begin errors++; $display("FAIL within_retrig got cnt %h err %b want cnt %h err 0010", bus.viol_cnt_o, bus.err_o, exp_cnt); end
        pulse_clr();
    endtask

    task automatic test_lat0_clamp();
        bus.mode_i[2] = 1'b0;
        bus.lat_i[2]  = 5'd0;
        bus.trig_i[2] = 1'b1; tick(); bus.trig_i[2] = 1'b0;
        checks++; if (bus.err_o !== 4'b0100 || bus.first_err_id_o !== 2'd2) begin errors++; $display("FAIL lat0_viol got err %b id %0d want 0100 id 2", bus.err_o, bus.first_err_id_o); end
        pulse_clr();
        bus.trig_i[2] = 1'b1; bus.cond_i[2] = 1'b1; tick(); bus.trig_i[2] = 1'b0; bus.cond_i[2] = 1'b0;
        checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL lat0_pass got %b want 0000", bus.err_o); end
        // lat 31 must clamp to 16: cond at T+16 satisfies AT
        bus.mode_i[2] = 1'b1;
        bus.lat_i[2]  = 5'd31;
        bus.trig_i[2] = 1'b1; tick(); bus.trig_i[2] = 1'b0;
        for (int k = 1; k <= 16; k++) begin bus.cond_i[2] = (k == 16); tick(); end
        bus.cond_i[2] = 1'b0;
        repeat (16) tick();
        checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL clamp_err got %b want 0000", bus.err_o); end
        bus.mode_i[2] = 1'b0;
        bus.lat_i[2]  = 5'd0;
        exp_cnt[2] = CNT_EN ? 8'd1 : 8'd0;
    endtask

    task automatic test_simultaneous();
        bus.lat_i[1] = 5'd0;
        bus.lat_i[3] = 5'd0;
        bus.mode_i   = '0;
        bus.trig_i = 4'b1010; tick(); bus.trig_i = '0;
        checks++; if (bus.err_o !== 4'b1010 || bus.first_err_id_o !== 2'd1 || bus.first_err_vld_o !== 1'b1) begin errors++; $display("FAIL simul_first got err %b id %0d vld %b want 1010 id 1 vld 1", bus.err_o, bus.first_err_id_o, bus.first_err_vld_o); end
        bus.lat_i[0] = 5'd0;
        bus.trig_i = 4'b0001; tick(); bus.trig_i = '0;
        checks++; if (bus.err_o !== 4'b1011 || bus.first_err_id_o !== 2'd1) begin errors++; $display("FAIL simul_later got err %b id %0d want 1011 id 1", bus.err_o, bus.first_err_id_o); end
        pulse_clr();
        checks++; if (bus.err_o !== 4'b0000 || bus.first_err_id_o !== 2'd0) begin errors++; $display("FAIL simul_clr got err %b id %0d want 0000 id 0", bus.err_o, bus.first_err_id_o); end
        exp_cnt[0] = CNT_EN ? 8'd2 : 8'd0;
        exp_cnt[1] = CNT_EN ? 8'd2 : 8'd0;
        exp_cnt[3] = CNT_EN ? 8'd1 : 8'd0;
    endtask

    task automatic test_clr_race();
        bus.trig_i = 4'b0001; tick(); bus.trig_i = '0;
        bus.clr_i = 1'b1; bus.trig_i = 4'b0100; tick();
        bus.clr_i = 1'b0; bus.trig_i = '0;
        checks++; if (bus.err_o !== 4'b0100 || bus.first_err_id_o !== 2'd2 || bus.first_err_vld_o !== 1'b1 || bus.irq_o !== 1'b1) begin errors++; $display("FAIL clr_race got err %b id %0d vld %b irq %b want 0100 id 2 vld 1 irq 1", bus.err_o, bus.first_err_id_o, bus.first_err_vld_o, bus.irq_o); end
        pulse_clr();
        exp_cnt[0] = CNT_EN ? 8'd3 : 8'd0;
        exp_cnt[2] = CNT_EN ? 8'd2 : 8'd0;
    endtask

    task automatic test_saturate();
        bus.trig_i[0] = 1'b1;
        repeat (300) tick();
        bus.trig_i[0] = 1'b0;
        exp_cnt[0] = CNT_EN ? 8'd255 : 8'd0;
        checks++; if (bus.viol_cnt_o !== exp_cnt) begin errors++; $display("FAIL sat_cnt got %h want %h", bus.viol_cnt_o, exp_cnt); end
        checks++; if (bus.err_o !== 4'b0001) begin errors++; $display("FAIL sat_err got %b want 0001", bus.err_o); end
        pulse_clr();
    endtask

    task automatic test_enable_drop();
        bus.lat_i[1] = 5'd4;
        bus.trig_i[1] = 1'b1; tick(); bus.trig_i[1] = 1'b0;
        tick();
        bus.chk_en_i[1] = 1'b0;
        repeat (5) tick();
        bus.chk_en_i[1] = 1'b1;
        repeat (6) tick();
        checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL en_drop_armed got %b want 0000", bus.err_o); end
        // violation in the very cycle enable falls is suppressed
        bus.chk_en_i[0] = 1'b0; bus.trig_i[0] = 1'b1; tick();
        bus.chk_en_i[0] = 1'b1; bus.trig_i[0] = 1'b0;
        bus.mode_i[3] = 1'b1; bus.lat_i[3] = 5'd2;
        bus.trig_i[3] = 1'b1; tick(); bus.trig_i[3] = 1'b0;
        tick();
        bus.chk_en_i[3] = 1'b0; tick(); bus.chk_en_i[3] = 1'b1;
        repeat (3) tick();
        checks++; if (bus.err_o !== 4'b0000 || bus.viol_cnt_o !== exp_cnt) begin errors++; $display("FAIL en_drop_same got err %b cnt %h want 0000 cnt %h", bus.err_o, bus.viol_cnt_o, exp_cnt); end
    endtask

    task automatic test_rst_mid();
        bus.lat_i[3] = 5'd5; bus.mode_i[3] = 1'b1;
        bus.trig_i = 4'b1100; tick(); bus.trig_i = '0;
        tick();
        checks++; if (bus.err_o !== 4'b0100) begin errors++; $display("FAIL rst_pre got %b want 0100", bus.err_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.err_o !== 4'b0000 || bus.irq_o !== 1'b0 || bus.first_err_vld_o !== 1'b0 || bus.first_err_id_o !== 2'd0) begin errors++; $display("FAIL rst_mid_out got err %b irq %b vld %b id %0d want all 0", bus.err_o, bus.irq_o, bus.first_err_vld_o, bus.first_err_id_o); end
        checks++; if (bus.viol_cnt_o !== '0) begin errors++; $display("FAIL rst_mid_cnt got %h want 0", bus.viol_cnt_o); end
        tick();
        rst = 1'b0;
        repeat (8) tick();
        checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL rst_abort got %b want 0000", bus.err_o); end
    endtask

    initial begin
        exp_cnt = '0;
        test_reset();
        test_at_mode();
        test_within();
        test_lat0_clamp();
        test_simultaneous();
        test_clr_race();
        test_saturate();
        test_enable_drop();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fc_prop_monitor.md
# fc_prop_monitor

Synthesizable, parametrised runtime property checker for the fuse-controller subsystem, instantiated next to the fuse controller in the Caliptra SS top. Each of NUM_CHK independent channels checks an implication of the form "trigger implies condition, either within N cycles or exactly N cycles later", e.g. escalation leading to the DAI error state, or a filter discard leading to an access error. Violations are latched as sticky per-channel errors with first-error capture, optional saturating counters and a level interrupt, so checks keep running in silicon and in emulation, not only in simulation.

## Interface
- NUM_CHK, 4: number of independent check channels (1..32).
- MAX_LAT, 16: largest programmable latency (1..255). LAT_W = $clog2(MAX_LAT+1).
- CNT_W, 8: violation counter width per channel.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous, active-high reset.
- chk_en_i  in  NUM_CHK  per-channel enable; when low the channel is forced to IDLE.
- trig_i  in  NUM_CHK  antecedent (trigger) per channel.
- cond_i  in  NUM_CHK  consequent (condition) per channel.
- mode_i  in  NUM_CHK  0 = WITHIN (cond in any cycle 1..lat after trigger), 1 = AT (cond exactly at cycle lat after trigger).
- lat_i  in  NUM_CHK*LAT_W  per-channel latency; sampled on trigger acceptance.
- clr_i  in  1  one-cycle pulse; clears sticky errors and first-error capture.
- err_o  out  NUM_CHK  sticky per-channel violation flags.
- first_err_vld_o  out  1  a first error has been captured.
- first_err_id_o  out  $clog2(NUM_CHK) (min 1)  index of the first violating channel.
- irq_o  out  1  OR of err_o.
- viol_cnt_o  out  NUM_CHK*CNT_W  saturating violation counters.

## Operation
- Per-channel FSM with states IDLE and ARMED, plus a down-counter cnt (LAT_W bits) and a latched mode bit.
- IDLE with chk_en_i & trig_i:
  - lat_i == 0: cond_i is checked in the same cycle (overlapping implication); a violation is flagged if it is low. State stays IDLE.
  - lat_i > 0: cnt <= lat_i, mode is latched, state -> ARMED.
  - lat_i > MAX_LAT: clamped to MAX_LAT.
- ARMED, WITHIN mode: cond_i high -> pass, go to IDLE. Otherwise, cnt == 1 -> violation, go to IDLE. Otherwise cnt decrements.
- ARMED, AT mode: cond_i is ignored while cnt > 1. At cnt == 1, cond_i low -> violation. In both cases the channel returns to IDLE.
- A trigger while ARMED is ignored (non-overlapping). A trigger in the cycle the channel returns to IDLE is also ignored; the next trigger is accepted one cycle later.
- chk_en_i low in any state: the channel goes to IDLE on the next edge, the pending check is dropped, and no violation is raised. A violation detected in the same cycle that chk_en_i falls is suppressed.
- On violation:
  - err_o[i] is set.
  - viol_cnt[i] increments, saturating at all-ones.
  - If first_err_vld_o is low, first_err_id_o is loaded and first_err_vld_o is set. Among simultaneous violations the lowest index wins.
- clr_i clears err_o, first_err_vld_o and first_err_id_o. Counters are not cleared.
- A violation in the same cycle as clr_i wins: the error bit ends set and the first error is recaptured.

## Timing
- Reset values: all FSMs IDLE, cnt = 0, err_o = 0, first_err_vld_o = 0, first_err_id_o = 0, irq_o = 0, viol_cnt_o = 0.
- All outputs are registered. A violation detected at edge-sampled cycle T is visible on err_o, irq_o, first_err_* and viol_cnt_o after the edge ending cycle T (T+1).
- With trigger at cycle T and lat L > 0: WITHIN checks cond_i in cycles T+1..T+L, and AT checks cond_i at T+L only.
- irq_o is the registered OR of the next err state, so it is coincident with err_o.
- Asserting rst_i mid-check aborts all channels immediately and returns every output to its reset value.

## Configuration
- FC_PROP_MON_VIOL_CNT_EN defined: per-channel saturating counters are present as described.
- FC_PROP_MON_VIOL_CNT_EN undefined: no counter flops are built, viol_cnt_o is tied to 0, and all other behaviour is identical.

## Test plan
- AT mode, ch0, lat = 10: trig at T, cond high only at T+10 -> no error. Repeat with cond high at T+9 only -> err_o[0] = 1 at T+11, first_err_id_o = 0, irq_o = 1.
- WITHIN mode, ch1, lat = 4: cond high at T+3 -> pass. Cond never high -> err_o[1] set at T+5. A retrigger at T+2 is ignored and yields no second count.
- lat = 0, ch2: trig with cond low -> err_o[2] at T+1. Trig with cond high -> no error.
- Simultaneous violations on ch3 and ch1 in the same cycle -> first_err_id_o = 1. A later ch0 violation leaves first_err_id_o = 1.
- clr_i pulse coincident with a ch2 violation -> err_o[2] stays 1 and first_err_id_o = 2. 300 violations on ch0 with CNT_W = 8 -> viol_cnt = 255.
- Drop chk_en_i while ARMED, or assert rst_i mid-check -> no error raised and all outputs return to reset values.
